// File: rtl/ram_loader_pkg.sv
// Shared defaults and FSM state encoding for the bit-serial RAM program loader.
package ram_loader_pkg;

  localparam int ADDR_W_DEFAULT = 4;
  localparam int DATA_W_DEFAULT = 8;
  localparam int RAM_DEPTH      = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_WRITE,
    ST_VRD,
    ST_VCMP,
    ST_DONE
  } state_t;

endpackage

// File: rtl/ram_loader_sync_edge.sv
// Multi-stage synchroniser for an asynchronous pin with a one-cycle rising-edge pulse.
module sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic level,
  output logic rise
);

  logic [STAGES-1:0] chain;
  logic              prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain <= '0;
      prev  <= 1'b0;
    end else begin
      chain <= {chain[STAGES-2:0], async_in};
      prev  <= chain[STAGES-1];
    end
  end

  assign level = chain[STAGES-1];
  assign rise  = level & ~prev;

endmodule

// File: rtl/ram_loader.sv
// Bit-serial program loader writing sequential RAM words from address 0 while holding the CPU.
// Optional readback check of every written word is enabled by defining RAM_LOADER_VERIFY_EN.
module ram_loader
  import ram_loader_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEFAULT,
  parameter int DATA_W      = DATA_W_DEFAULT,
  parameter int SYNC_STAGES = 2
) (
  input  logic              CLK,
  input  logic              RESETn,
  input  logic              LD_EN,
  input  logic              LD_SCK,
  input  logic              LD_SDI,
  input  logic [DATA_W-1:0] DOUT,
  output logic [ADDR_W-1:0] ADDR,
  output logic [DATA_W-1:0] DIN,
  output logic              RI,
  output logic              HALT,
  output logic              DONE,
  output logic              ERR
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  logic en_level, en_rise;
  logic sck_level_unused, sck_rise;
  logic sdi_level, sdi_rise_unused;

  sync_edge #(.STAGES(SYNC_STAGES)) u_sync_en (
    .clk(CLK), .rst_n(RESETn), .async_in(LD_EN), .level(en_level), .rise(en_rise)
  );
  sync_edge #(.STAGES(SYNC_STAGES)) u_sync_sck (
    .clk(CLK), .rst_n(RESETn), .async_in(LD_SCK), .level(sck_level_unused), .rise(sck_rise)
  );
  sync_edge #(.STAGES(SYNC_STAGES)) u_sync_sdi (
    .clk(CLK), .rst_n(RESETn), .async_in(LD_SDI), .level(sdi_level), .rise(sdi_rise_unused)
  );

  state_t            state, next_state;
  logic [DATA_W-1:0] shift_reg, hold_reg, shift_next;
  logic [CNT_W-1:0]  bit_cnt;
  logic [ADDR_W-1:0] pointer, addr_reg;
  logic              done_reg;
  logic              shift_active, byte_done;
  logic              start_session, advance, set_err;

  // Shifting keeps running through WRITE and verify so the next byte is never lost.
  assign shift_active = en_level && (state inside {ST_SHIFT, ST_WRITE, ST_VRD, ST_VCMP});
  assign byte_done    = shift_active && sck_rise && (bit_cnt == CNT_W'(DATA_W - 1));
  assign shift_next   = {shift_reg[DATA_W-2:0], sdi_level};

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      shift_reg <= '0;
      hold_reg  <= '0;
      bit_cnt   <= '0;
    end else if (!shift_active) begin
      bit_cnt <= '0;
    end else if (sck_rise) begin
      shift_reg <= shift_next;
      bit_cnt   <= byte_done ? '0 : bit_cnt + 1'b1;
      if (byte_done) begin
        hold_reg <= shift_next;
      end
    end
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Abort (synced LD_EN low) takes priority over every other transition.
  always_comb begin
    next_state    = state;
    start_session = 1'b0;
    advance       = 1'b0;
    set_err       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (en_rise) begin
          next_state    = ST_SHIFT;
          start_session = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (!en_level)      next_state = ST_IDLE;
        else if (byte_done) next_state = ST_WRITE;
      end
      ST_WRITE: begin
        if (!en_level) begin
          next_state = ST_IDLE;
        end else begin
`ifdef RAM_LOADER_VERIFY_EN
          next_state = ST_VRD;
`else
          advance    = 1'b1;
`endif
        end
      end
`ifdef RAM_LOADER_VERIFY_EN
      ST_VRD: begin
        next_state = en_level ? ST_VCMP : ST_IDLE;
      end
      ST_VCMP: begin
        if (!en_level) begin
          next_state = ST_IDLE;
        end else begin
          advance = 1'b1;
          set_err = (DOUT != hold_reg);
        end
      end
`endif
      ST_DONE: begin
        if (!en_level) next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
    if (advance) begin
      next_state = (&pointer) ? ST_DONE : ST_SHIFT;
    end
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      pointer  <= '0;
      addr_reg <= '0;
      done_reg <= 1'b0;
    end else begin
      if (start_session) begin
        pointer  <= '0;
        done_reg <= 1'b0;
      end else if (advance) begin
        if (&pointer) done_reg <= 1'b1;
        else          pointer  <= pointer + 1'b1;
      end
      if (state == ST_SHIFT && next_state == ST_WRITE) begin
        addr_reg <= pointer;
      end
    end
  end

`ifdef RAM_LOADER_VERIFY_EN
  logic err_reg;

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      err_reg <= 1'b0;
    end else if (start_session) begin
      err_reg <= 1'b0;
    end else if (set_err) begin
      err_reg <= 1'b1;
    end
  end

  assign ERR = err_reg;
`else
  logic dout_unused;
  logic set_err_unused;

  assign dout_unused    = ^DOUT;
  assign set_err_unused = set_err;
  assign ERR            = 1'b0;
`endif

  assign ADDR = addr_reg;
  assign DIN  = hold_reg;
  assign RI   = (state == ST_WRITE);
  assign HALT = (state != ST_IDLE);
  assign DONE = done_reg;

endmodule

// File: tb/tb_ram_loader.sv
// Directed self-checking bench for ram_loader with a behavioural 16x8 RAM model.
module tb_ram_loader;

  logic       CLK = 1'b0;
  logic       RESETn;
  logic       LD_EN, LD_SCK, LD_SDI;
  logic [7:0] DOUT;
  logic [3:0] ADDR;
  logic [7:0] DIN;
  logic       RI, HALT, DONE, ERR;

  int check_count = 0;
  int error_count = 0;

  logic [7:0] ram [16];
  logic [3:0] log_addr [64];
  logic [7:0] log_data [64];
  int         wr_count = 0;
  logic       force_zero = 1'b0;

  ram_loader dut (
    .CLK(CLK), .RESETn(RESETn), .LD_EN(LD_EN), .LD_SCK(LD_SCK), .LD_SDI(LD_SDI),
    .DOUT(DOUT), .ADDR(ADDR), .DIN(DIN), .RI(RI), .HALT(HALT), .DONE(DONE), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  // RAM write side, sampled mid-cycle; every write is logged for later checks.
  always @(negedge CLK) begin
    if (RI === 1'b1 && RESETn === 1'b1) begin
      ram[ADDR] = DIN;
      if (wr_count < 64) begin
        log_addr[wr_count] = ADDR;
        log_data[wr_count] = DIN;
      end
      wr_count++;
    end
  end

  always @(posedge CLK) begin
    DOUT <= (force_zero && ADDR == 4'd7) ? 8'h00 : ram[ADDR];
  end

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    check_count++;
    if (observed !== expected) begin
      error_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic send_bit(input logic b);
    LD_SDI = b;
    LD_SCK = 1'b0;
    wait_cycles(4);
    LD_SCK = 1'b1;
    wait_cycles(4);
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
  endtask

  task automatic start_session();
    LD_EN = 1'b1;
    wait_cycles(5);
  endtask

  task automatic end_session();
    LD_EN = 1'b0;
    wait_cycles(5);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int  base;
    bit  found;
    for (int i = 0; i < 16; i++) ram[i] = 8'h00;
    RESETn = 1'b0;
    LD_EN  = 1'b0;
    LD_SCK = 1'b0;
    LD_SDI = 1'b0;
    wait_cycles(3);
    check_output("reset_addr", ADDR, 0);
    check_output("reset_din",  DIN,  0);
    check_output("reset_ri",   RI,   0);
    check_output("reset_halt", HALT, 0);
    check_output("reset_done", DONE, 0);
    check_output("reset_err",  ERR,  0);
    RESETn = 1'b1;
    wait_cycles(3);

    $display("[TB] full 16-byte load");
    base = wr_count;
    start_session();
    check_output("load_halt_start", HALT, 1);
    for (int i = 0; i < 16; i++) send_byte(8'(i * 8'h11));
    wait_cycles(4);
    check_output("load_ri_count", wr_count - base, 16);
    for (int i = 0; i < 16; i++) begin
      check_output($sformatf("load_addr_%0d", i), log_addr[base + i], i);
      check_output($sformatf("load_data_%0d", i), log_data[base + i], 8'(i * 8'h11));
    end
    check_output("load_done", DONE, 1);
    check_output("load_halt", HALT, 1);
    check_output("load_err",  ERR,  0);

    $display("[TB] extra SCK edges in DONE");
    send_byte(8'hA5);
    wait_cycles(4);
    check_output("done_extra_ri", wr_count - base, 16);
    check_output("done_extra_addr", ADDR, 15);
    check_output("done_extra_din", DIN, 8'hFF);
    end_session();
    check_output("end_halt", HALT, 0);
    check_output("end_done_kept", DONE, 1);

    $display("[TB] back-to-back session then abort");
    base = wr_count;
    start_session();
    check_output("b2b_done_cleared", DONE, 0);
    send_byte(8'h3C);
    send_byte(8'h01);
    send_byte(8'h02);
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    LD_EN = 1'b0;
    wait_cycles(4);
    check_output("abort_halt", HALT, 0);
    check_output("abort_done", DONE, 0);
    check_output("abort_ri_count", wr_count - base, 3);
    check_output("b2b_ram0", ram[0], 8'h3C);
    check_output("abort_ram1", ram[1], 8'h01);
    check_output("abort_ram2", ram[2], 8'h02);
    check_output("abort_ram3_kept", ram[3], 8'h33);
    check_output("b2b_first_addr", log_addr[base], 0);

    $display("[TB] reset during write cycle");
    start_session();
    send_byte(8'h10);
    for (int i = 7; i >= 1; i--) send_bit(1'b1);
    LD_SDI = 1'b1;
    LD_SCK = 1'b0;
    wait_cycles(4);
    LD_SCK = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      if (RI === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
    check_output("rst_ri_seen", found, 1);
    RESETn = 1'b0;
    #1;
    check_output("rst_ri_drop", RI, 0);
    check_output("rst_halt_drop", HALT, 0);
    LD_EN  = 1'b0;
    LD_SCK = 1'b0;
    wait_cycles(2);
    RESETn = 1'b1;
    wait_cycles(2);
    base = wr_count;
    start_session();
    send_byte(8'h42);
    wait_cycles(4);
    check_output("rst_new_count", wr_count - base, 1);
    check_output("rst_new_addr", log_addr[base], 0);
    check_output("rst_new_data", log_data[base], 8'h42);
    end_session();

`ifdef RAM_LOADER_VERIFY_EN
    $display("[TB] readback verify with forced mismatch at address 7");
    force_zero = 1'b1;
    base = wr_count;
    start_session();
    check_output("vfy_err_start", ERR, 0);
    for (int i = 0; i < 16; i++) begin
      send_byte((i == 7) ? 8'h5A : 8'(i));
      if (i == 6) begin
        wait_cycles(4);
        check_output("vfy_err_before", ERR, 0);
      end
      if (i == 7) begin
        wait_cycles(4);
        check_output("vfy_err_set", ERR, 1);
      end
    end
    wait_cycles(6);
    check_output("vfy_count", wr_count - base, 16);
    check_output("vfy_data7", log_data[base + 7], 8'h5A);
    check_output("vfy_done", DONE, 1);
    check_output("vfy_err_at_done", ERR, 1);
    end_session();
    check_output("vfy_err_idle", ERR, 1);
    force_zero = 1'b0;
    start_session();
    check_output("vfy_err_cleared", ERR, 0);
    end_session();
`endif

    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end

endmodule
